// File: rtl/serial_adder_ctrl_if.sv
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
// The requester drives the master side; the adder core sits on the slave side.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Sub;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             V;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, Cin, Sub,
        input  S, Cout, V, busy, done
    );

    modport slave (
        input  start, A, B, Cin, Sub,
        output S, Cout, V, busy, done
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor: one full adder is reused LSB-first over WIDTH cycles,
// with the result, carry-out and signed overflow published only on completion.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              rst,
    serial_adder_ctrl_if.slave bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    logic             carry_q, carry_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             v_q, v_d;

    logic a_bit, b_bit, sum_bit, carry_out;

    // Shared 1-bit full adder.
    always_comb begin
        a_bit     = ra_q[0];
        b_bit     = rb_q[0];
        sum_bit   = a_bit ^ b_bit ^ carry_q;
        carry_out = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
    end

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        s_d     = s_q;
        cout_d  = cout_q;
        v_d     = v_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1, so Cin is overridden in that mode.
                    ra_d    = bus.A;
                    rb_d    = bus.Sub ? ~bus.B : bus.B;
                    carry_d = bus.Sub ? 1'b1 : bus.Cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                ra_d    = {1'b0, ra_q[WIDTH-1:1]};
                rb_d    = {1'b0, rb_q[WIDTH-1:1]};
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                carry_d = carry_out;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    // carry_q here is the carry into the MSB; xor with its carry-out is V.
                    s_d     = {sum_bit, res_q[WIDTH-1:1]};
                    cout_d  = carry_out;
                    v_d     = carry_q ^ carry_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            v_q     <= v_d;
        end
    end

    assign bus.S    = s_q;
    assign bus.Cout = cout_q;
    assign bus.V    = v_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);

    busy_done_exclusive : assert property (@(posedge clk) disable iff (rst)
        !(bus.busy && bus.done));

    done_single_cycle : assert property (@(posedge clk) disable iff (rst)
        bus.done |=> !bus.done);

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus randomized traffic,
// all compared every cycle against a latency-level arithmetic model.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {V, Cout, S}.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic cin, input logic sub);
        logic [W-1:0] bop;
        logic [W:0]   full;
        logic         ovf;
        bop  = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bop} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
        ovf  = (a[W-1] == bop[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full[W], full[W-1:0]};
    endfunction

    // Model: phase 0 idle, 1..W busy, W+1 done.
    int           m_phase = 0;
    logic [W-1:0] m_s     = '0;
    logic         m_cout  = 1'b0;
    logic         m_v     = 1'b0;
    logic [W+1:0] m_pend  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_s     <= '0;
            m_cout  <= 1'b0;
            m_v     <= 1'b0;
        end else if (m_phase == 0) begin
            if (bus.start) begin
                m_pend  <= ref_add(bus.A, bus.B, bus.Cin, bus.Sub);
                m_phase <= 1;
            end
        end else if (m_phase < int'(W)) begin
            m_phase <= m_phase + 1;
        end else if (m_phase == int'(W)) begin
            m_phase <= W + 1;
            m_s     <= m_pend[W-1:0];
            m_cout  <= m_pend[W];
            m_v     <= m_pend[W+1];
        end else begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        check("cyc.S",    32'(bus.S),    32'(m_s));
        check("cyc.Cout", 32'(bus.Cout), 32'(m_cout));
        check("cyc.V",    32'(bus.V),    32'(m_v));
        check("cyc.busy", 32'(bus.busy), 32'((m_phase >= 1) && (m_phase <= int'(W))));
        check("cyc.done", 32'(bus.done), 32'(m_phase == int'(W) + 1));
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic sub, input logic [W-1:0] exp_s, input logic exp_c,
                          input logic exp_v, input string tag);
        int busy_cnt = 0;
        int done_cyc = 0;
        @(posedge clk);
        #1;
        bus.A     = a;
        bus.B     = b;
        bus.Cin   = cin;
        bus.Sub   = sub;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = W'($urandom);
        bus.B     = W'($urandom);
        bus.Cin   = 1'($urandom);
        bus.Sub   = 1'($urandom);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cyc = k;
                break;
            end
        end
        check({tag, ".done_cycle"}, 32'(done_cyc), 32'(W + 1));
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(W));
        check({tag, ".S"}, 32'(bus.S), 32'(exp_s));
        check({tag, ".Cout"}, 32'(bus.Cout), 32'(exp_c));
        check({tag, ".V"}, 32'(bus.V), 32'(exp_v));
    endtask

    initial begin
        logic busy_hist [1:12];
        logic done_hist [1:12];
        logic [W-1:0] s_at9;
        int done_seen;
        int wait_cyc;

        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Cin   = 1'b0;
        bus.Sub   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset.S",    32'(bus.S),    32'h0);
        check("reset.Cout", 32'(bus.Cout), 32'h0);
        check("reset.V",    32'(bus.V),    32'h0);
        check("reset.busy", 32'(bus.busy), 32'h0);
        check("reset.done", 32'(bus.done), 32'h0);
        rst = 1'b0;

        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run_op(8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, "add_7f_cin");
        run_op(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, "sub_05_07");

        // start held high; operands change in RUN cycle 3.
        @(posedge clk);
        #1;
        bus.A     = 8'h3C;
        bus.B     = 8'h21;
        bus.Cin   = 1'b0;
        bus.Sub   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        s_at9 = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            busy_hist[k] = bus.busy;
            done_hist[k] = bus.done;
            if (k == 9) s_at9 = bus.S;
            if (k == 3) begin
                bus.A = 8'h10;
                bus.B = 8'h22;
            end
        end
        check("held.done_c9",  32'(done_hist[9]),  32'h1);
        check("held.S",        32'(s_at9),         32'h5D);
        check("held.busy_c10", 32'(busy_hist[10]), 32'h0);
        check("held.busy_c11", 32'(busy_hist[11]), 32'h1);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_cyc  = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.done) begin
                wait_cyc = k;
                break;
            end
        end
        check("held.second_done_seen", 32'(wait_cyc != 0), 32'h1);
        check("held.second_S", 32'(bus.S), 32'h32);

        // Reset in RUN cycle 4 aborts the operation.
        @(posedge clk);
        #1;
        bus.A     = 8'h33;
        bus.B     = 8'h44;
        bus.Cin   = 1'b0;
        bus.Sub   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort.S",    32'(bus.S),    32'h0);
        check("abort.Cout", 32'(bus.Cout), 32'h0);
        check("abort.V",    32'(bus.V),    32'h0);
        check("abort.busy", 32'(bus.busy), 32'h0);
        check("abort.done", 32'(bus.done), 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        done_seen = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        check("abort.no_done", 32'(done_seen), 32'h0);
        check("abort.S_kept",  32'(bus.S),     32'h0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, "after_reset");

        // Random traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            bus.A     = W'($urandom);
            bus.B     = W'($urandom);
            bus.Cin   = 1'($urandom);
            bus.Sub   = 1'($urandom);
            bus.start = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (W + 4) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
